// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the pipelined execute-stage ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_MUL  = 4'b1010
    } alu_op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus Z/N/V/C for all single-cycle ops.
// MUL is not handled here; it decodes as unknown (result 0).
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_z,
    output logic             o_n,
    output logic             o_v,
    output logic             o_c
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_v_add;
    logic             w_v_sub;
    logic [SHW-1:0]   w_shamt;

    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff  = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_v_add = (i_a[WIDTH-1] == i_b[WIDTH-1]) & (w_sum[WIDTH-1]  != i_a[WIDTH-1]);
    assign w_v_sub = (i_a[WIDTH-1] != i_b[WIDTH-1]) & (w_diff[WIDTH-1] != i_a[WIDTH-1]);
    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        o_v      = 1'b0;
        o_c      = 1'b0;
        case (alu_op_e'(i_op))
            ALU_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                o_v      = w_v_add;
                o_c      = w_sum[WIDTH];
            end
            ALU_SUB: begin
                o_result = w_diff[WIDTH-1:0];
                o_v      = w_v_sub;
                o_c      = w_diff[WIDTH];
            end
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            // Signed less-than is N^V of A-B, which stays correct on overflow.
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_v_sub};
            ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, ~w_diff[WIDTH]};
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $signed(i_a) >>> w_shamt;
            default:  o_result = '0;
        endcase
    end

    assign o_z = ~|o_result;
    assign o_n = o_result[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, latency 1 for single-cycle ops.
// Define ALU_MUL_EN to add the iterative shift-add multiplier (opcode 1010).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Z,
    output logic             N,
    output logic             V,
    output logic             C
);

    logic [WIDTH-1:0] r_result;
    logic             r_valid;
    logic             r_z, r_n, r_v, r_c;

    logic [WIDTH-1:0] w_res;
    logic             w_z, w_n, w_v, w_c;
    logic             w_accept;
    logic             w_load_core;

    alu_core #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_core (
        .i_a      (A),
        .i_b      (B),
        .i_op     (ALUControl),
        .o_result (w_res),
        .o_z      (w_z),
        .o_n      (w_n),
        .o_v      (w_v),
        .o_c      (w_c)
    );

    assign w_accept = in_valid & in_ready;

`ifdef ALU_MUL_EN
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [SHW:0]     r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_mul_start;
    logic             w_mul_last;

    assign in_ready    = (r_state == ST_IDLE) & (~r_valid | out_ready);
    assign w_mul_start = w_accept & (ALUControl == ALU_MUL);
    assign w_mul_last  = (r_state == ST_MUL_BUSY) & (r_cnt == CNT_LAST);
    assign w_acc_nxt   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_load_core = w_accept & ~w_mul_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_mul_start) w_state_nxt = ST_MUL_BUSY;
            ST_MUL_BUSY: if (w_mul_last)  w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // One multiplier bit per busy cycle; the last step writes the output directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (w_mul_start) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= A;
            r_mplier <= B;
        end else if (r_state == ST_MUL_BUSY) begin
            r_cnt    <= r_cnt + 1'b1;
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end
`else
    assign in_ready    = ~r_valid | out_ready;
    assign w_load_core = w_accept;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
        end else if (w_load_core) begin
            r_valid  <= 1'b1;
            r_result <= w_res;
            r_z      <= w_z;
            r_n      <= w_n;
            r_v      <= w_v;
            r_c      <= w_c;
`ifdef ALU_MUL_EN
        end else if (w_mul_last) begin
            r_valid  <= 1'b1;
            r_result <= w_acc_nxt;
            r_z      <= ~|w_acc_nxt;
            r_n      <= w_acc_nxt[WIDTH-1];
            r_v      <= 1'b0;
            r_c      <= 1'b0;
`endif
        end else if (out_ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign Result    = r_result;
    assign Z         = r_z;
    assign N         = r_n;
    assign V         = r_v;
    assign C         = r_c;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases, back-pressure,
// reset and a randomized stream scored against a behavioural model.
module tb_alu_pipe;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic        z, n, v, c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A, B, Result;
    logic [3:0]  ALUControl;
    logic        Z, N, V, C;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   cyc   = 0;
    int   n0, c2, c3;

    alu_pipe #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .Z          (Z),
        .N          (N),
        .V          (V),
        .C          (C)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural definitions.
    function automatic exp_t ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, s;
        logic [63:0] p;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: begin
                e.r = a + b;
                s   = sa + sb;
                e.c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                e.r = a - b;
                s   = sa - sb;
                e.c = (a >= b);
                e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: e.r = a & b;
            4'd3: e.r = a | b;
            4'd4: e.r = a ^ b;
            4'd5: e.r = (sa < sb) ? 32'd1 : 32'd0;
            4'd6: e.r = (a < b) ? 32'd1 : 32'd0;
            4'd7: e.r = a << b[4:0];
            4'd8: e.r = a >> b[4:0];
            4'd9: e.r = 32'(sa >>> b[4:0]);
`ifdef ALU_MUL_EN
            4'd10: begin
                p   = {32'b0, a} * {32'b0, b};
                e.r = p[31:0];
            end
`endif
            default: e.r = 32'd0;
        endcase
        e.z = (e.r == 32'd0);
        e.n = e.r[31];
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0:       return 32'h0000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Scoreboard: every held result is compared against the oldest expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
        end else begin
`ifndef ALU_MUL_EN
            check("out_valid", 64'(out_valid), 64'(q.size() != 0));
            check("in_ready", 64'(in_ready), 64'(q.size() == 0 || out_ready));
`endif
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    check("result", {28'b0, Result, Z, N, V, C}, 64'(q[0]));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(ref_op(ALUControl, A, B));
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        in_valid   = 1'b1;
        ALUControl = op;
        A          = a;
        B          = b;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic run_dir(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [35:0] exp, input int exp_lat);
        int lat;
        out_ready = 1'b1;
        issue(op, a, b);
        lat = 1;
        while (!out_valid && lat < 100) begin
`ifdef ALU_MUL_EN
            check({tag, "_busy_rdy"}, 64'(in_ready), 64'd0);
`endif
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check(tag, {28'b0, Result, Z, N, V, C}, {28'b0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        A          = '0;
        B          = '0;
        ALUControl = '0;
        #2 rst = 1'b0;
        #1 check("rst_state", {27'b0, out_valid, Result, Z, N, V, C}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_inrdy", 64'(in_ready), 64'd1);

        // Directed corner cases; flag nibble is {Z,N,V,C}.
        run_dir("add_ovf", ALU_ADD,  32'h7FFF_FFFF, 32'h1, {32'h8000_0000, 4'b0110}, 1);
        run_dir("sub_neg", ALU_SUB,  32'hFFFF_FFFF, 32'h1, {32'hFFFF_FFFE, 4'b0101}, 1);
        run_dir("slt",     ALU_SLT,  32'hFFFF_FFFF, 32'h1, {32'h0000_0001, 4'b0000}, 1);
        run_dir("sltu",    ALU_SLTU, 32'hFFFF_FFFF, 32'h1, {32'h0000_0000, 4'b1000}, 1);
        run_dir("sub_eq",  ALU_SUB,  32'h5, 32'h5,         {32'h0000_0000, 4'b1001}, 1);
        run_dir("sra",     ALU_SRA,  32'h8000_0000, 32'h24, {32'hF800_0000, 4'b0100}, 1);
        run_dir("srl",     ALU_SRL,  32'h8000_0000, 32'h24, {32'h0800_0000, 4'b0000}, 1);
        run_dir("sll",     ALU_SLL,  32'h8000_0000, 32'h24, {32'h0000_0000, 4'b1000}, 1);
        run_dir("unk_op",  4'b1111,  32'h1234_5678, 32'h9,  {32'h0000_0000, 4'b1000}, 1);
`ifdef ALU_MUL_EN
        run_dir("mul",     ALU_MUL,  32'h0001_0003, 32'h0002_0005, {32'h000B_000F, 4'b0000}, 33);
`else
        run_dir("mul_off", 4'b1010,  32'h0001_0003, 32'h0002_0005, {32'h0000_0000, 4'b1000}, 1);
`endif

        // Back-pressure: first result stalls two cycles, then stream resumes.
        out_ready = 1'b1;
        n0 = n_out;
        issue(ALU_ADD, 32'd1, 32'd2);
        out_ready = 1'b0;
        fork
            begin
                issue(ALU_ADD, 32'd3, 32'd4);
                c2 = cyc;
                issue(ALU_ADD, 32'd5, 32'd6);
                c3 = cyc;
            end
            begin
                @(negedge clk);
                check("bp_hold_rdy", 64'(in_ready), 64'd0);
                check("bp_hold_res", 64'(Result), 64'd3);
                @(posedge clk);
                @(negedge clk);
                check("bp_hold_res2", 64'(Result), 64'd3);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        check("bp_count", 64'(n_out - n0), 64'd3);
        check("bp_thruput", 64'(c3 - c2), 64'd1);

        // Reset while a result is held under back-pressure.
        out_ready = 1'b0;
        issue(ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("rst_async", {27'b0, out_valid, Result, Z, N, V, C}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        check("rst_mid_inrdy", 64'(in_ready), 64'd1);

        // Randomized stream with random back-pressure.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            in_valid   = ($urandom_range(3) != 0);
            out_ready  = ($urandom_range(3) != 0);
            ALUControl = 4'($urandom_range(15));
            A          = pick();
            B          = pick();
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (q.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
